// File: rtl/decode_pkg.sv
// Shared opcode constants, default field widths, the decoded-instruction struct
// and the opcode legality helper for the decode stage.
package decode_pkg;

  localparam int OP_W_DEF   = 5;
  localparam int MODE_W_DEF = 2;
  localparam int REG_W_DEF  = 5;
  localparam int LIT_W_DEF  = 32;
  localparam int SEQ_W_DEF  = 4;

  localparam logic [4:0] OP_NOP   = 5'h00;
  localparam logic [4:0] OP_LOAD  = 5'h01;
  localparam logic [4:0] OP_STORE = 5'h02;
  localparam logic [4:0] OP_ADD   = 5'h08;
  localparam logic [4:0] OP_SUB   = 5'h09;
  localparam logic [4:0] OP_AND   = 5'h0A;
  localparam logic [4:0] OP_OR    = 5'h0B;
  localparam logic [4:0] OP_XOR   = 5'h0C;
  localparam logic [4:0] OP_SHL   = 5'h0D;
  localparam logic [4:0] OP_SHR   = 5'h0E;
  localparam logic [4:0] OP_BEQ   = 5'h10;
  localparam logic [4:0] OP_BNE   = 5'h11;
  localparam logic [4:0] OP_JMP   = 5'h12;

  // Decoded instruction at the default widths; decode_stage builds the same
  // layout from its own parameters.
  typedef struct packed {
    logic [OP_W_DEF-1:0]   op;
    logic [MODE_W_DEF-1:0] mode;
    logic [REG_W_DEF-1:0]  src;
    logic [REG_W_DEF-1:0]  dst;
    logic [LIT_W_DEF-1:0]  lit;
    logic                  branch;
    logic                  store;
    logic                  load;
    logic                  illegal;
    logic [SEQ_W_DEF-1:0]  seq;
  } dec_instr_t;

  // Opcodes arrive zero-extended to 16 bits so any OP_W up to 16 can use this.
  function automatic logic is_defined_op(input logic [15:0] op);
    case (op)
      16'(OP_NOP), 16'(OP_LOAD), 16'(OP_STORE),
      16'(OP_ADD), 16'(OP_SUB), 16'(OP_AND), 16'(OP_OR),
      16'(OP_XOR), 16'(OP_SHL), 16'(OP_SHR),
      16'(OP_BEQ), 16'(OP_BNE), 16'(OP_JMP): is_defined_op = 1'b1;
      default:                               is_defined_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_skid_buf.sv
// Two-slot valid/ready skid buffer (output register + skid register) with flush.
// Handshake: a transfer happens on an edge where valid && ready; valid never
// depends on ready, and the payload is stable while valid is held without ready.
module decode_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         accept;
  logic         issue;

  assign in_ready = !skid_valid && !flush && !rst;
  assign accept   = in_valid && in_ready;
  assign issue    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // A same-cycle issue has already been seen downstream; just drop the rest.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || issue) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage: field split + classification in front of
// a skid buffer, with a per-accept sequence tag. Optional DECODE_ILLEGAL_EN flags undefined opcodes.
module decode_stage
  import decode_pkg::*;
#(
  parameter int OP_W   = 5,
  parameter int MODE_W = 2,
  parameter int REG_W  = 5,
  parameter int LIT_W  = 32,
  parameter int SEQ_W  = 4,
  localparam int INSTR_W = OP_W + MODE_W + 2*REG_W + LIT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    out_op,
  output logic [MODE_W-1:0]  out_mode,
  output logic [REG_W-1:0]   out_src,
  output logic [REG_W-1:0]   out_dst,
  output logic [LIT_W-1:0]   out_lit,
  output logic               out_branch,
  output logic               out_store,
  output logic               out_load,
  output logic               out_illegal,
  output logic [SEQ_W-1:0]   out_seq
);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [MODE_W-1:0] mode;
    logic [REG_W-1:0]  src;
    logic [REG_W-1:0]  dst;
    logic [LIT_W-1:0]  lit;
    logic              branch;
    logic              store;
    logic              load;
    logic              illegal;
    logic [SEQ_W-1:0]  seq;
  } dec_t;

  dec_t             dec;
  dec_t             held;
  logic [SEQ_W-1:0] seq_cnt;
  logic             accept;
  logic [15:0]      op_ext;

  assign accept = in_valid && in_ready;
  assign op_ext = 16'(in_instr[INSTR_W-1 -: OP_W]);

  always_comb begin
    dec = '0;
    {dec.op, dec.mode, dec.src, dec.dst, dec.lit} = in_instr;
    dec.branch = (op_ext == 16'(OP_BEQ)) || (op_ext == 16'(OP_BNE)) ||
                 (op_ext == 16'(OP_JMP));
    dec.store  = (op_ext == 16'(OP_STORE));
    dec.load   = (op_ext == 16'(OP_LOAD));
`ifdef DECODE_ILLEGAL_EN
    dec.illegal = !is_defined_op(op_ext);
`else
    dec.illegal = 1'b0;
`endif
    dec.seq = seq_cnt;
  end

  // Flush does not rewind the tag so downstream can tell pre- and post-flush work apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_cnt <= '0;
    end else if (accept) begin
      seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  decode_skid_buf #(
    .W($bits(dec_t))
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (held)
  );

  assign out_op      = held.op;
  assign out_mode    = held.mode;
  assign out_src     = held.src;
  assign out_dst     = held.dst;
  assign out_lit     = held.lit;
  assign out_branch  = held.branch;
  assign out_store   = held.store;
  assign out_load    = held.load;
  assign out_illegal = held.illegal;
  assign out_seq     = held.seq;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic
// against a queue-based model of the stage (build with or without DECODE_ILLEGAL_EN).
module tb_decode_stage;

  localparam int OP_W    = 5;
  localparam int MODE_W  = 2;
  localparam int REG_W   = 5;
  localparam int LIT_W   = 32;
  localparam int SEQ_W   = 4;
  localparam int INSTR_W = OP_W + MODE_W + 2*REG_W + LIT_W;
  localparam int V_W     = INSTR_W + 4 + SEQ_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [OP_W-1:0]    out_op;
  logic [MODE_W-1:0]  out_mode;
  logic [REG_W-1:0]   out_src;
  logic [REG_W-1:0]   out_dst;
  logic [LIT_W-1:0]   out_lit;
  logic               out_branch;
  logic               out_store;
  logic               out_load;
  logic               out_illegal;
  logic [SEQ_W-1:0]   out_seq;

  int checks = 0;
  int failures = 0;
  int seq_m = 0;
  logic [V_W-1:0] exp_q[$];

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_mode(out_mode), .out_src(out_src), .out_dst(out_dst),
    .out_lit(out_lit), .out_branch(out_branch), .out_store(out_store),
    .out_load(out_load), .out_illegal(out_illegal), .out_seq(out_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [INSTR_W-1:0] mk(input int op, input int mode, input int src,
                                            input int dst, input logic [31:0] lit);
    longint unsigned w;
    w = (longint'(op) << 44) + (longint'(mode) << 42) + (longint'(src) << 37) +
        (longint'(dst) << 32) + longint'(lit);
    return INSTR_W'(w);
  endfunction

  function automatic logic [INSTR_W-1:0] rnd_instr();
    return mk($urandom_range(0, 31), $urandom_range(0, 3), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom);
  endfunction

  // Expected presentation of an instruction, derived from the field layout and opcode table.
  function automatic logic [V_W-1:0] model(input logic [INSTR_W-1:0] instr, input int seq);
    longint unsigned w;
    int op, mode, src, dst;
    logic br, st, ld, ill;
    logic [31:0] lit;
    w    = longint'(instr);
    op   = int'((w >> 44) & 31);
    mode = int'((w >> 42) & 3);
    src  = int'((w >> 37) & 31);
    dst  = int'((w >> 32) & 31);
    lit  = 32'(w & 64'hFFFF_FFFF);
    br   = (op == 16) || (op == 17) || (op == 18);
    st   = (op == 2);
    ld   = (op == 1);
`ifdef DECODE_ILLEGAL_EN
    ill  = !(op inside {0, 1, 2, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18});
`else
    ill  = 1'b0;
`endif
    return {5'(op), 2'(mode), 5'(src), 5'(dst), lit, br, st, ld, ill, 4'(seq % 16)};
  endfunction

  function automatic logic [V_W-1:0] obs();
    return {out_op, out_mode, out_src, out_dst, out_lit,
            out_branch, out_store, out_load, out_illegal, out_seq};
  endfunction

  // One clock cycle: drive at the falling edge, check and update the model just after.
  task automatic cycle(input logic v, input logic [INSTR_W-1:0] instr,
                       input logic ordy, input logic fl);
    logic can_acc;
    @(negedge clk);
    in_valid  = v;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
    #1;
    can_acc = (exp_q.size() < 2) && !fl;
    chk("in_ready", in_ready, can_acc);
    chk("out_valid", out_valid, exp_q.size() > 0);
    if (exp_q.size() > 0 && ordy) chk("issue", obs(), exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (v && can_acc) begin
      exp_q.push_back(model(instr, seq_m));
      seq_m++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0;
    exp_q.delete();
    seq_m = 0;
    #1;
    chk("rst_out_fields", obs(), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_release_ready", in_ready, 1);
  endtask

  initial begin
    do_reset();

    cycle(1, 49'h1_0464_DEAD_BEEF, 1, 0);
    cycle(0, '0, 1, 0);
    chk("beef_op", out_op, 5'h10);
    chk("beef_mode", out_mode, 1);
    chk("beef_src", out_src, 3);
    chk("beef_dst", out_dst, 4);
    chk("beef_lit", out_lit, 32'hDEADBEEF);
    chk("beef_branch", out_branch, 1);
    chk("beef_store", out_store, 0);
    chk("beef_seq", out_seq, 0);

    cycle(1, mk(2, 0, 7, 9, 32'h1234), 1, 0);
    cycle(1, mk(1, 2, 4, 6, 32'h5678), 1, 0);
    chk("stream_store", out_store, 1);
    chk("stream_seq0", out_seq, 1);
    cycle(0, '0, 1, 0);
    chk("stream_load", out_load, 1);
    chk("stream_seq1", out_seq, 2);

    do_reset();
    repeat (3) cycle(1, rnd_instr(), 0, 0);
    chk("hold_in_ready", in_ready, 0);
    cycle(1, rnd_instr(), 0, 1);
    cycle(1, mk(8, 1, 1, 1, 32'hCAFE), 1, 0);
    cycle(0, '0, 1, 0);
    chk("flush_seq", out_seq, 2);

    repeat (4) cycle(1, rnd_instr(), 0, 0);
    repeat (3) cycle(0, '0, 1, 0);
    cycle(1, rnd_instr(), 0, 0);
    cycle(1, rnd_instr(), 1, 0);
    cycle(1, rnd_instr(), 0, 0);
    repeat (3) cycle(1, rnd_instr(), 1, 0);

    do_reset();
    repeat (17) cycle(1, rnd_instr(), 1, 0);
    cycle(0, '0, 1, 0);
    chk("wrap_seq", out_seq, 0);

    cycle(1, mk(31, 0, 0, 0, 32'h0), 1, 0);
    cycle(0, '0, 1, 0);
`ifdef DECODE_ILLEGAL_EN
    chk("illegal_1f", out_illegal, 1);
`else
    chk("illegal_1f", out_illegal, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 9) < 7, rnd_instr(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 99) < 3);
    end
    repeat (3) cycle(0, '0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage between instruction fetch and the data path. Splits each instruction word into op/mode/src/dst/literal fields, classifies it (branch, store, load, illegal), and presents the result on a valid/ready interface. A one-entry skid buffer absorbs back-pressure without losing throughput. A per-instruction sequence tag supports downstream tracking and flushes.

## Interface
Parameters:
- OP_W, 5, opcode field width
- MODE_W, 2, addressing-mode field width
- REG_W, 5, register-index width (src and dst)
- LIT_W, 32, literal/source field width
- SEQ_W, 4, sequence-tag width
- INSTR_W, OP_W+MODE_W+2*REG_W+LIT_W (49), derived; not overridable

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill everything held in the stage this cycle
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  INSTR_W  instruction word; field order MSB→LSB: op, mode, src, dst, lit
- out_valid  out  1  decoded instruction available
- out_ready  in  1  data path consumes this cycle
- out_op  out  OP_W; out_mode  out  MODE_W; out_src  out  REG_W; out_dst  out  REG_W; out_lit  out  LIT_W
- out_branch  out  1  op ∈ {OP_BEQ, OP_BNE, OP_JMP}
- out_store  out  1  op == OP_STORE
- out_load  out  1  op == OP_LOAD
- out_illegal  out  1  undefined opcode (see Configuration)
- out_seq  out  SEQ_W  sequence tag of the presented instruction

## Operation
- Accept: in_valid && in_ready. Issue: out_valid && out_ready.
- Two storage slots: output register (drives out_*) and skid register.
- in_ready = !skid_valid && !flush && !rst (combinational from registered state plus flush/rst).
- On accept: if output slot empty or issuing this cycle, the decoded word loads the output slot; otherwise it loads the skid slot.
- On issue with skid full: the skid word moves to the output slot, skid empties.
- Decode (classification flags, field split) happens before registering; every out_* is a flop output.
- Sequence counter seq_cnt: increments by 1 (mod 2^SEQ_W) on every accept; the accepted word carries the pre-increment value. Wraps 2^SEQ_W−1 → 0. Unaffected by flush.
- flush: output and skid valid bits clear at the next edge; no accept that cycle; an issue in the same cycle still completes (data path saw it). seq_cnt holds.
- out_* data fields hold their last value when out_valid=0; only valid bits are cleared.
- Ordering is strictly FIFO; no instruction is duplicated or dropped except by flush/rst.

## Timing
- Latency: accept at edge N → out_valid high after edge N, same cycle as the next accept opportunity (1 cycle).
- Throughput: 1 instruction/cycle while out_ready=1.
- out_ready low one cycle: one instruction lands in skid, in_ready drops next cycle, recovers the cycle after out_ready returns high.
- Reset: out_valid=0, skid empty, seq_cnt=0, all out_* data fields and flags 0; in_ready=0 while rst high, 1 the first cycle after.
- rst dominates flush and any handshake in the same cycle.

## Configuration
- DECODE_ILLEGAL_EN defined: out_illegal=1 for any op outside the package's defined opcode list; instruction still flows through and issues normally (data path traps).
- Undefined: out_illegal tied 0; all opcodes pass unflagged.

## Structure
- decode_pkg: opcode constants (OP_LOAD=5'h01, OP_STORE=5'h02, OP_BEQ=5'h10, OP_BNE=5'h11, OP_JMP=5'h12, plus ALU ops), a packed decoded-instruction struct (fields + flags + seq), and a function is_defined_op.
- Sub-module decode_skid_buf: generic two-slot valid/ready skid buffer on the packed struct with flush; decode_stage wraps combinational decode and seq_cnt around it.

## Test plan
- Reset, then in_instr=49'h1_0464_DEAD_BEEF, valid 1 cycle, out_ready=1 → next cycle out_op=5'h10, mode=1, src=3, dst=4, lit=32'hDEADBEEF, branch=1, store=0, seq=0.
- Stream op=5'h02 then op=5'h01, back to back → store=1 then load=1, seq 0 then 1, one per cycle.
- Hold out_ready=0 with in_valid=1 continuously → exactly 2 accepted, in_ready=0 from the third cycle; release → both issue in order, no loss.
- flush while both slots full → out_valid=0 next cycle, in_ready=1 next cycle, next accept carries seq=2 (counter not rewound).
- 17 accepts with SEQ_W=4 → seq 0…15 then 0.
- With DECODE_ILLEGAL_EN, op=5'h1F → out_illegal=1; without it → out_illegal=0.
